// File: rtl/counter8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter8_seq_ctrl
//
// Sequencing controller for an 8-bit loadable up-counter. It loads a captured
// preset into the counter, lets it run to a captured target, stops the counter
// exactly on the target and pulses done. It supports pause (level), abort, and
// an optional periodic auto-reload mode.
//
// Optional feature macro: COUNTER8_SEQ_AUTO_RELOAD_EN
//   defined   : a match with mode_q=1 reloads the preset and runs again,
//               period_cnt counts completed periods.
//   undefined : auto_reload is ignored, period_cnt is tied to 0, every match
//               ends in DONE.
//
// Ports:
//   clock          in   single clock
//   clear          in   synchronous active-high reset
//   start          in   command pulse, accepted in IDLE/DONE only
//   abort          in   return to IDLE on next edge (priority below clear)
//   pause          in   level, halts the counter while in RUN
//   auto_reload    in   periodic-mode select, captured with start
//   preset[7:0]    in   counter start value, captured with start
//   target[7:0]    in   counter terminal value, captured with start
//   ctr_count[7:0] in   count output of the controlled counter
//   ctr_load       out  counter load
//   ctr_start_stop out  counter enable
//   ctr_data[7:0]  out  counter load data (the captured preset)
//   ready          out  high in IDLE and DONE
//   busy           out  high in LOAD and RUN
//   done           out  one-cycle completion pulse
//   period_cnt[7:0] out completed auto-reload periods, wraps 255->0
// -----------------------------------------------------------------------------
module counter8_seq_ctrl (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  input  logic       auto_reload,
  input  logic [7:0] preset,
  input  logic [7:0] target,
  input  logic [7:0] ctr_count,
  output logic       ctr_load,
  output logic       ctr_start_stop,
  output logic [7:0] ctr_data,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] period_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_preset;
  logic [7:0] r_target;
  logic       r_mode;
  logic [7:0] r_period;

  logic       w_match;
  logic       w_capture_mode;
  logic       w_reload;

  // The counter is compared against the target every RUN cycle, so a match
  // also covers preset == target (zero count edges).
  assign w_match = (r_state == S_RUN) && (ctr_count == r_target);

`ifdef COUNTER8_SEQ_AUTO_RELOAD_EN
  assign w_capture_mode = auto_reload;
  assign w_reload       = r_mode;
`else
  logic w_unused_auto_reload;
  assign w_unused_auto_reload = auto_reload;
  assign w_capture_mode       = 1'b0;
  assign w_reload             = 1'b0;
`endif

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state  <= S_IDLE;
      r_preset <= 8'd0;
      r_target <= 8'd0;
      r_mode   <= 1'b0;
      r_period <= 8'd0;
    end else if (abort) begin
      // Abort leaves captured values and period_cnt untouched.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_LOAD;
            r_preset <= preset;
            r_target <= target;
            r_mode   <= w_capture_mode;
          end
        end
        S_LOAD: r_state <= S_RUN;
        S_RUN: begin
          if (w_match) begin
            if (w_reload) begin
              r_state  <= S_LOAD;
              r_period <= r_period + 8'd1;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Counter controls are decoded combinationally from the state so the
  // counter is stopped in the very cycle it reaches the target and never
  // overshoots. Abort suppresses every strobe in its own cycle.
  assign ctr_load       = (r_state == S_LOAD) && !abort;
  assign ctr_start_stop = (r_state == S_RUN) && !pause && !w_match && !abort;
  assign done           = w_match && !abort;
  assign ctr_data       = r_preset;
  assign ready          = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy           = (r_state == S_LOAD) || (r_state == S_RUN);

`ifdef COUNTER8_SEQ_AUTO_RELOAD_EN
  assign period_cnt = r_period;
`else
  logic [7:0] w_unused_period;
  assign w_unused_period = r_period;
  assign period_cnt      = 8'd0;
`endif

endmodule
